// File: rtl/dmem_access_ctrl_if.sv
// Word-aligned request/acknowledge bus between the memory-stage access controller and data memory.
// master = controller (drives request), slave = memory (drives ack and read data).
interface dmem_access_ctrl_if #(
  parameter int N = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store controller: IDLE -> ACCESS (until ack or TIMEOUT) -> DONE; zero-wait access = 3 cycles.
// Holds the pipeline via combinational stall while a request is pending in IDLE or in flight.
module dmem_access_ctrl #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRd,
  input  logic                  memWr,
  input  logic [2:0]            funct,
  input  logic [N-1:0]          addr,
  input  logic [N-1:0]          wr_data,
  dmem_access_ctrl_if.master    mem,
  output logic [N-1:0]          dt_out,
  output logic                  stall,
  output logic                  misalign,
  output logic                  bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [N-1:0]  r_mem_addr;
  logic [N-1:0]  r_mem_wdata;
  logic [3:0]    r_mem_be;
  logic [N-1:0]  r_dt;
  logic          r_misalign;
  logic          r_bus_err;
  logic          r_rd;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic [CW-1:0] r_cnt;

  logic          w_req_vld;
  logic [1:0]    w_size;
  logic          w_err;
  logic [3:0]    w_be;
  logic [N-1:0]  w_wdata;
  logic [N-1:0]  w_rdata_sh;
  logic [N-1:0]  w_rdata_ext;
  logic          w_timeout;

  assign w_req_vld = memRd | memWr;
  assign w_size    = funct[1:0];
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // A simultaneous read and write is treated as a read, so read legality rules apply.
  always_comb begin
    w_err = 1'b0;
    if (memRd) begin
      if (funct == 3'b011 || funct == 3'b110 || funct == 3'b111) w_err = 1'b1;
    end else if (funct[2] || funct == 3'b011) begin
      w_err = 1'b1;
    end
    if (w_size == 2'b01 && addr[0])          w_err = 1'b1;
    if (w_size == 2'b10 && addr[1:0] != 2'b00) w_err = 1'b1;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wr_data;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wr_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_rdata_sh = mem.mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_rdata_ext = w_rdata_sh;
    case (r_size)
      2'b00:   w_rdata_ext = {{(N-8){1'b0}},  w_rdata_sh[7:0]};
      2'b01:   w_rdata_ext = {{(N-16){1'b0}}, w_rdata_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_dt        <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_rd        <= 1'b0;
      r_lane      <= '0;
      r_size      <= '0;
      r_cnt       <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_vld) begin
            if (w_err) begin
              r_misalign <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= memWr & ~memRd;
              r_mem_addr  <= {addr[N-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_rd        <= memRd;
              r_lane      <= addr[1:0];
              r_size      <= w_size;
              r_cnt       <= '0;
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          // Ack takes priority over a timeout firing in the same cycle.
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_rd) r_dt <= w_rdata_ext;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            if (r_rd) r_dt <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall = rst_n & (((r_state == S_IDLE) & w_req_vld) | (r_state == S_ACCESS));

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_be    = r_mem_be;
  assign dt_out        = r_dt;
  assign misalign      = r_misalign;
  assign bus_err       = r_bus_err;

endmodule
